// File: rtl/polara_noc_traffic_gen.sv
// polara_noc_traffic_gen
// Chipset-side NoC traffic generator for Polara bring-up. A burst is started
// with go. Each packet is one header flit followed by 0..MAX_PAYLOAD payload
// flits, all driven on a single NoC chosen when the burst starts.
//
// Ports:
//   chipset_clk, chip_rst     clock, asynchronous active-high reset
//   go / stop                 start a burst / finish the current packet and idle
//   chan_sel, pattern_mode,   burst configuration, latched at go
//   payload_len, num_packets,
//   gap_cycles
//   noc_data/noc_val/noc_rdy  flattened per-channel flit buses with rdy/val handshake
//   intf_chipset_rdy          tied low; this block never receives
//   busy, done, sel_err       status: burst active, end-of-burst pulse, bad chan_sel pulse
//   pkt_count                 packets fully sent since the last go
//   signature                 rolling XOR signature of accepted flits
//
// Optional feature macro: POLARA_TRAFFIC_GEN_SIGNATURE_EN enables the signature
// register. When it is undefined, signature is tied to zero.
module polara_noc_traffic_gen #(
  parameter int NOC_DATA_WIDTH = 64,
  parameter int NUM_NOCS       = 3,
  parameter int MAX_PAYLOAD    = 64,
  parameter int SEL_W          = 2
) (
  input  logic                               chipset_clk,
  input  logic                               chip_rst,
  input  logic                               go,
  input  logic                               stop,
  input  logic [SEL_W-1:0]                   chan_sel,
  input  logic [1:0]                         pattern_mode,
  input  logic [7:0]                         payload_len,
  input  logic [7:0]                         num_packets,
  input  logic [7:0]                         gap_cycles,
  output logic [NUM_NOCS*NOC_DATA_WIDTH-1:0] noc_data,
  output logic [NUM_NOCS-1:0]                noc_val,
  input  logic [NUM_NOCS-1:0]                noc_rdy,
  output logic [NUM_NOCS-1:0]                intf_chipset_rdy,
  output logic                               busy,
  output logic                               done,
  output logic                               sel_err,
  output logic [15:0]                        pkt_count,
  output logic [NOC_DATA_WIDTH-1:0]          signature
);

  localparam int W = NOC_DATA_WIDTH;
  localparam logic [31:0] PRBS_SEED = 32'hACE10001;

  typedef enum logic [2:0] {IDLE, HDR, DATA, GAP, FIN} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_r;
  logic [1:0]       mode_r;
  logic [7:0]       len_r;
  logic [7:0]       npk_r;
  logic [7:0]       gap_r;
  logic [7:0]       gap_cnt;
  logic [7:0]       k_r;
  logic [31:0]      prbs;
  logic             stop_seen;
  logic             val_r;
  logic [W-1:0]     flit_r;

  logic             sel_ok;
  logic             rdy_sel;
  logic             hs;
  logic             pkt_end;
  logic             last_pkt;
  logic [15:0]      pkt_next;
  logic [7:0]       len_clamp;

  // Invalidation-forward header; bits above 63 stay zero.
  function automatic logic [W-1:0] hdr_flit(input logic [7:0] len, input logic [7:0] mshr);
    logic [W-1:0] f;
    f       = '0;
    f[63:0] = {14'b10000000000000, 8'd0, 8'd0, 4'b0010, len, 8'd18, mshr, 6'd0};
    return f;
  endfunction

  function automatic logic [W-1:0] payload_flit(input logic [1:0] mode, input logic [7:0] k,
                                                input logic [15:0] pk, input logic [31:0] p);
    logic [W-1:0] f;
    f = '0;
    case (mode)
      2'd1: f = W'(1) << (32'(k) % W);
      2'd2: f[31:0] = {pk, 8'h00, k};
      2'd3: for (int unsigned i = 0; i < W / 32; i++) f[i*32 +: 32] = p;
      default: f = '0;
    endcase
    return f;
  endfunction

  // Fibonacci LFSR, x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] prbs_step(input logic [31:0] p);
    return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
  endfunction

  always_comb begin
    sel_ok  = 1'b0;
    rdy_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_NOCS; i++) begin
      if (chan_sel == SEL_W'(i)) sel_ok = 1'b1;
      if (sel_r == SEL_W'(i))    rdy_sel = noc_rdy[i];
    end
    hs        = val_r & rdy_sel;
    pkt_end   = hs && ((state == HDR && len_r == 8'd0) ||
                       (state == DATA && k_r == len_r - 8'd1));
    pkt_next  = pkt_count + 16'd1;
    last_pkt  = stop_seen || stop || (npk_r != 8'd0 && pkt_next == {8'h00, npk_r});
    len_clamp = (payload_len > 8'(MAX_PAYLOAD)) ? 8'(MAX_PAYLOAD) : payload_len;
  end

  always_ff @(posedge chipset_clk or posedge chip_rst) begin
    if (chip_rst) begin
      state     <= IDLE;
      sel_r     <= '0;
      mode_r    <= '0;
      len_r     <= '0;
      npk_r     <= '0;
      gap_r     <= '0;
      gap_cnt   <= '0;
      k_r       <= '0;
      prbs      <= PRBS_SEED;
      stop_seen <= 1'b0;
      val_r     <= 1'b0;
      flit_r    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
      pkt_count <= '0;
    end else begin
      done    <= 1'b0;
      sel_err <= 1'b0;
      if (state != IDLE && stop) stop_seen <= 1'b1;

      case (state)
        IDLE: begin
          if (go) begin
            if (sel_ok) begin
              sel_r     <= chan_sel;
              mode_r    <= pattern_mode;
              len_r     <= len_clamp;
              npk_r     <= num_packets;
              gap_r     <= gap_cycles;
              pkt_count <= '0;
              prbs      <= PRBS_SEED;
              stop_seen <= 1'b0;
              k_r       <= '0;
              val_r     <= 1'b1;
              flit_r    <= hdr_flit(len_clamp, 8'd0);
              busy      <= 1'b1;
              state     <= HDR;
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (hs && len_r != 8'd0) begin
            k_r    <= '0;
            flit_r <= payload_flit(mode_r, 8'd0, pkt_count, prbs);
            state  <= DATA;
          end
        end
        DATA: begin
          if (hs) begin
            prbs   <= prbs_step(prbs);
            k_r    <= k_r + 8'd1;
            // The flit after k uses the LFSR value that is being stored this cycle.
            flit_r <= payload_flit(mode_r, k_r + 8'd1, pkt_count, prbs_step(prbs));
          end
        end
        GAP: begin
          if (gap_cnt <= 8'd1) begin
            val_r  <= 1'b1;
            flit_r <= hdr_flit(len_r, pkt_count[7:0]);
            state  <= HDR;
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Packet completion overrides the per-state next-flit assignments above.
      if (pkt_end) begin
        pkt_count <= pkt_next;
        if (last_pkt) begin
          val_r  <= 1'b0;
          flit_r <= '0;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= FIN;
        end else if (gap_r != 8'd0) begin
          val_r   <= 1'b0;
          flit_r  <= '0;
          gap_cnt <= gap_r;
          state   <= GAP;
        end else begin
          val_r  <= 1'b1;
          flit_r <= hdr_flit(len_r, pkt_next[7:0]);
          state  <= HDR;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_NOCS; i++) begin : g_chan
    assign noc_val[i]           = val_r && (sel_r == SEL_W'(i));
    assign noc_data[i*W +: W]   = noc_val[i] ? flit_r : '0;
  end

  assign intf_chipset_rdy = '0;

`ifdef POLARA_TRAFFIC_GEN_SIGNATURE_EN
  logic [W-1:0] sig_r;

  always_ff @(posedge chipset_clk or posedge chip_rst) begin
    if (chip_rst) begin
      sig_r <= '0;
    end else if (state == IDLE && go && sel_ok) begin
      sig_r <= '0;
    end else if (hs) begin
      sig_r <= {sig_r[W-2:0], sig_r[W-1]} ^ flit_r;
    end
  end

  assign signature = sig_r;
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_polara_noc_traffic_gen.sv
module tb_polara_noc_traffic_gen;
  localparam int W = 64;
  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             go, stop;
  logic [1:0]       chan_sel, pattern_mode;
  logic [7:0]       payload_len, num_packets, gap_cycles;
  logic [N*W-1:0]   noc_data;
  logic [N-1:0]     noc_val, noc_rdy, intf_chipset_rdy;
  logic             busy, done, sel_err;
  logic [15:0]      pkt_count;
  logic [W-1:0]     signature;

  polara_noc_traffic_gen #(
    .NOC_DATA_WIDTH(W),
    .NUM_NOCS(N),
    .MAX_PAYLOAD(64),
    .SEL_W(2)
  ) dut (
    .chipset_clk(clk), .chip_rst(rst), .go(go), .stop(stop),
    .chan_sel(chan_sel), .pattern_mode(pattern_mode), .payload_len(payload_len),
    .num_packets(num_packets), .gap_cycles(gap_cycles),
    .noc_data(noc_data), .noc_val(noc_val), .noc_rdy(noc_rdy),
    .intf_chipset_rdy(intf_chipset_rdy), .busy(busy), .done(done),
    .sel_err(sel_err), .pkt_count(pkt_count), .signature(signature)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: records accepted flits and protocol anomalies at the falling edge.
  typedef struct { int chan; logic [W-1:0] data; } acc_t;
  acc_t          acc_q[$];
  int            low_cnt, hold_err, chan_err, nval;
  logic          prev_wait [N];
  logic [W-1:0]  prev_data [N];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) prev_wait[i] = 1'b0;
    end else begin
      nval = 0;
      for (int i = 0; i < N; i++) begin
        if (noc_val[i]) nval++;
        else if (noc_data[i*W +: W] != '0) chan_err++;
        if (prev_wait[i] && (!noc_val[i] || noc_data[i*W +: W] !== prev_data[i])) hold_err++;
        prev_wait[i] = noc_val[i] && !noc_rdy[i];
        prev_data[i] = noc_data[i*W +: W];
        if (noc_val[i] && noc_rdy[i]) acc_q.push_back('{chan: i, data: noc_data[i*W +: W]});
      end
      if (nval > 1) chan_err++;
      if (busy && nval == 0) low_cnt++;
    end
  end

  // Reference model: expected flit stream of a burst, straight from the packet rules.
  logic [W-1:0] exp_q[$];

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    int   taps[4] = '{32, 22, 2, 1};
    logic fb = 1'b0;
    foreach (taps[t]) fb = fb ^ s[taps[t]-1];
    return {s[30:0], fb};
  endfunction

  function automatic logic [W-1:0] model_hdr(input int len, input int pk);
    return (64'h1 << 63) | (64'h2 << 30) | (64'(len) << 22) | (64'(18) << 14) | (64'(pk % 256) << 6);
  endfunction

  task automatic build_expected(input int mode, input int len_in, input int npk);
    int           len;
    logic [31:0]  s;
    logic [W-1:0] f;
    len = (len_in > 64) ? 64 : len_in;
    s   = 32'hACE10001;
    exp_q.delete();
    for (int p = 0; p < npk; p++) begin
      exp_q.push_back(model_hdr(len, p));
      for (int k = 0; k < len; k++) begin
        case (mode)
          1: f = 64'(1) << (k % W);
          2: f = 64'(((p % 65536) * 65536) + k);
          3: f = {s, s};
          default: f = '0;
        endcase
        exp_q.push_back(f);
        s = lfsr_step(s);
      end
    end
  endtask

  // rdy_style: 0 always ready, 1 selected ready on every third cycle, 2 random.
  task automatic run_burst(input string tag, input int chan, input int mode, input int len,
                           input int npk, input int gap, input int rdy_style, input int stop_pkt);
    int exp_pkts, cyc, scount;
    bit seen;
    exp_pkts = (stop_pkt >= 0) ? stop_pkt + 1 : npk;
    build_expected(mode, len, exp_pkts);
    @(posedge clk); #1;
    acc_q.delete(); low_cnt = 0; hold_err = 0; chan_err = 0;
    chan_sel = 2'(chan); pattern_mode = 2'(mode); payload_len = 8'(len);
    num_packets = 8'(npk); gap_cycles = 8'(gap); go = 1'b1;
    noc_rdy = (rdy_style == 0) ? 3'b111 : 3'(1 << chan);
    @(posedge clk); #1;
    go = 1'b0;
    chan_sel = 2'($urandom); pattern_mode = 2'($urandom); payload_len = 8'($urandom);
    num_packets = 8'($urandom); gap_cycles = 8'($urandom);
    seen = 1'b0; cyc = 0; scount = 0;
    while (!seen && cyc < 20000) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
        case (rdy_style)
          0: noc_rdy = 3'b111;
          1: begin noc_rdy = 3'($urandom); noc_rdy[chan] = (cyc % 3 == 0); end
          default: noc_rdy = 3'($urandom);
        endcase
        if (stop_pkt >= 0 && int'(pkt_count) == stop_pkt) scount++;
        stop = (scount == 10);
      end
    end
    check({tag, "_done_seen"}, W'(seen), W'(1));
    check({tag, "_busy_at_done"}, W'(busy), W'(0));
    check({tag, "_pkt_count"}, W'(pkt_count), W'(exp_pkts));
    check({tag, "_gap_low_cycles"}, W'(low_cnt), W'(gap * (exp_pkts - 1)));
    check({tag, "_hold_errors"}, W'(hold_err), W'(0));
    check({tag, "_channel_errors"}, W'(chan_err), W'(0));
    check({tag, "_flit_count"}, W'(acc_q.size()), W'(exp_q.size()));
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_flit%0d_chan", tag, i), W'(acc_q[i].chan), W'(chan));
      check($sformatf("%s_flit%0d_data", tag, i), acc_q[i].data, exp_q[i]);
    end
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, W'(done), W'(0));
    check({tag, "_idle_busy"}, W'(busy), W'(0));
  endtask

  initial begin
    int c, m, l, np, g;
    rst = 1'b1; go = 1'b0; stop = 1'b0; chan_sel = '0; pattern_mode = '0;
    payload_len = '0; num_packets = '0; gap_cycles = '0; noc_rdy = '0;
    low_cnt = 0; hold_err = 0; chan_err = 0;
    repeat (3) @(negedge clk);
    check("rst_val", W'(noc_val), W'(0));
    check("rst_data", noc_data[W-1:0] | noc_data[2*W-1:W] | noc_data[3*W-1:2*W], '0);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_sel_err", W'(sel_err), W'(0));
    check("rst_pkt_count", W'(pkt_count), W'(0));
    check("rst_signature", signature, '0);
    check("rst_intf_rdy", W'(intf_chipset_rdy), W'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    run_burst("walk1", 1, 1, 4, 1, 0, 0, -1);
    run_burst("walk1_throttle", 1, 1, 4, 1, 0, 1, -1);
    run_burst("hdr_only", 0, 2, 0, 3, 2, 0, -1);
    run_burst("prbs_stop", 2, 3, 200, 0, 1, 0, 2);
    check("prbs_first_payload", (acc_q.size() > 1) ? acc_q[1].data : '0, 64'hACE10001ACE10001);

    for (int r = 0; r < 4; r++) begin
      c  = $urandom_range(0, 2);
      m  = $urandom_range(0, 3);
      l  = $urandom_range(0, 70);
      np = $urandom_range(1, 3);
      g  = $urandom_range(0, 3);
      run_burst($sformatf("rand%0d", r), c, m, l, np, g, 2, -1);
    end

    // Out-of-range channel select.
    @(posedge clk); #1;
    chan_sel = 2'd3; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    check("sel_err_pulse", W'(sel_err), W'(1));
    check("sel_err_busy", W'(busy), W'(0));
    @(negedge clk);
    check("sel_err_one_cycle", W'(sel_err), W'(0));
    check("sel_err_still_idle", W'(busy), W'(0));

    // Reset in the middle of a packet.
    @(posedge clk); #1;
    chan_sel = 2'd0; pattern_mode = 2'd1; payload_len = 8'd64; num_packets = 8'd1;
    gap_cycles = 8'd0; noc_rdy = 3'b111; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", W'(busy), W'(1));
    check("mid_val", W'(noc_val), W'(3'b001));
    #2 rst = 1'b1;
    #1;
    check("rst_mid_val", W'(noc_val), W'(0));
    check("rst_mid_busy", W'(busy), W'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_pkt_count", W'(pkt_count), W'(0));
    check("rst_mid_still_idle", W'(noc_val), W'(0));

    // Signature over a one-payload zero packet.
    run_burst("sig", 0, 0, 1, 1, 0, 0, -1);
`ifdef POLARA_TRAFFIC_GEN_SIGNATURE_EN
    begin
      logic [W-1:0] h;
      h = model_hdr(1, 0);
      check("signature", signature, {h[W-2:0], h[W-1]});
    end
`else
    check("signature_tied", signature, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
